// File: rtl/state_dump_ctrl.sv
// state_dump_ctrl: streams a snapshot of the core's register file and data memory
// out through a valid/ready beat interface.
//
// Beat order: 16 register pairs (kind 00), MEM_BYTES/4 little-endian memory words
// (kind 01), then an optional XOR checksum beat (kind 10) when DUMP_CHECKSUM_EN is
// defined. Without DUMP_CHECKSUM_EN no checksum state or logic is built.
//
// Parameter
//   MEM_BYTES   bytes of data memory dumped; must be a multiple of 4 and >= 4
// Ports
//   clk, reset              clock, synchronous active-high reset
//   start                   begin a dump (only looked at while idle)
//   dumpActive              core ports are steered to this block
//   regAddr1/2, regData1/2  register-file read ports (data valid same cycle)
//   memAddr, memRead        data-memory byte address and read enable
//   memDataIn               data-memory read data, bits [7:0] used
//   outValid, outReady      beat handshake
//   outKind, outIndex       beat type and index within its type
//   outDataHi, outDataLo    beat payload
//   done                    one-cycle pulse after the final beat is accepted
module state_dump_ctrl #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        dumpActive,
    output logic [4:0]  regAddr1,
    output logic [4:0]  regAddr2,
    input  logic [31:0] regData1,
    input  logic [31:0] regData2,
    output logic [31:0] memAddr,
    output logic        memRead,
    input  logic [31:0] memDataIn,
    output logic        outValid,
    input  logic        outReady,
    output logic [1:0]  outKind,
    output logic [7:0]  outIndex,
    output logic [31:0] outDataHi,
    output logic [31:0] outDataLo,
    output logic        done
);

    localparam int unsigned ADDR_W = $clog2(MEM_BYTES + 1);
    localparam int unsigned PAIR_W = 4;
    localparam logic [1:0]  KIND_REG = 2'b00;
    localparam logic [1:0]  KIND_MEM = 2'b01;
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(15);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REG_LOAD   = 3'd1,
        REG_EMIT   = 3'd2,
        MEM_GATHER = 3'd3,
        MEM_EMIT   = 3'd4
`ifdef DUMP_CHECKSUM_EN
        ,
        SUM_EMIT   = 3'd5
`endif
    } state_t;

    state_t              state, stateNext;
    logic [PAIR_W-1:0]   pairCnt, pairNext;
    logic [ADDR_W-1:0]   byteAddr, addrNext;
    logic [31:0]         hiNext, loNext;
    logic [1:0]          kindNext;
    logic [7:0]          indexNext;
    logic                doneNext;
    logic                activeNext;
    logic                validNext;
    logic                memReadNext;
    logic [31:0]         memAddrNext;
    logic [4:0]          regAddr1Next, regAddr2Next;

`ifdef DUMP_CHECKSUM_EN
    localparam logic [1:0] KIND_SUM = 2'b10;
    logic [31:0] checksum, sumNext;
    logic [31:0] beatXor;
    assign beatXor = outDataHi ^ outDataLo;
`endif

    // Only the low byte of the memory bus carries data.
    logic unusedMemBits;
    assign unusedMemBits = ^memDataIn[31:8];

    // Next-state, datapath and next-output logic.
    always_comb begin
        stateNext = state;
        pairNext  = pairCnt;
        addrNext  = byteAddr;
        hiNext    = outDataHi;
        loNext    = outDataLo;
        kindNext  = outKind;
        indexNext = outIndex;
        doneNext  = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        sumNext   = checksum;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = REG_LOAD;
                    pairNext  = '0;
`ifdef DUMP_CHECKSUM_EN
                    sumNext   = '0;
`endif
                end
            end

            REG_LOAD: begin
                hiNext    = regData1;
                loNext    = regData2;
                kindNext  = KIND_REG;
                indexNext = 8'(pairCnt);
                stateNext = REG_EMIT;
            end

            REG_EMIT: begin
                if (outReady) begin
`ifdef DUMP_CHECKSUM_EN
                    sumNext = checksum ^ beatXor;
`endif
                    if (pairCnt == LAST_PAIR) begin
                        stateNext = MEM_GATHER;
                        addrNext  = '0;
                    end else begin
                        pairNext  = pairCnt + PAIR_W'(1);
                        stateNext = REG_LOAD;
                    end
                end
            end

            MEM_GATHER: begin
                // Byte lane follows the low address bits: little-endian packing.
                loNext[{byteAddr[1:0], 3'b000} +: 8] = memDataIn[7:0];
                addrNext = byteAddr + ADDR_W'(1);
                if (byteAddr[1:0] == 2'd3) begin
                    stateNext = MEM_EMIT;
                    hiNext    = '0;
                    kindNext  = KIND_MEM;
                    indexNext = 8'(byteAddr >> 2);
                end
            end

            MEM_EMIT: begin
                if (outReady) begin
`ifdef DUMP_CHECKSUM_EN
                    sumNext = checksum ^ beatXor;
`endif
                    // byteAddr already points at the next word's base here.
                    if (byteAddr < ADDR_W'(MEM_BYTES)) begin
                        stateNext = MEM_GATHER;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        stateNext = SUM_EMIT;
                        hiNext    = '0;
                        loNext    = checksum ^ beatXor;
                        kindNext  = KIND_SUM;
                        indexNext = '0;
`else
                        stateNext = IDLE;
                        doneNext  = 1'b1;
`endif
                    end
                end
            end

`ifdef DUMP_CHECKSUM_EN
            SUM_EMIT: begin
                if (outReady) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end
            end
`endif

            default: stateNext = IDLE;
        endcase

        // Sideband outputs are registered from the state being entered.
        activeNext   = (stateNext != IDLE);
        validNext    = (stateNext == REG_EMIT) || (stateNext == MEM_EMIT)
`ifdef DUMP_CHECKSUM_EN
                       || (stateNext == SUM_EMIT)
`endif
                       ;
        memReadNext  = (stateNext == MEM_GATHER);
        memAddrNext  = (stateNext == MEM_GATHER) ? 32'(addrNext) : '0;
        regAddr1Next = (stateNext == REG_LOAD) ? {pairNext, 1'b0} : '0;
        regAddr2Next = (stateNext == REG_LOAD) ? {pairNext, 1'b1} : '0;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pairCnt    <= '0;
            byteAddr   <= '0;
            dumpActive <= 1'b0;
            outValid   <= 1'b0;
            outKind    <= '0;
            outIndex   <= '0;
            outDataHi  <= '0;
            outDataLo  <= '0;
            done       <= 1'b0;
            memRead    <= 1'b0;
            memAddr    <= '0;
            regAddr1   <= '0;
            regAddr2   <= '0;
`ifdef DUMP_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            state      <= stateNext;
            pairCnt    <= pairNext;
            byteAddr   <= addrNext;
            dumpActive <= activeNext;
            outValid   <= validNext;
            outKind    <= kindNext;
            outIndex   <= indexNext;
            outDataHi  <= hiNext;
            outDataLo  <= loNext;
            done       <= doneNext;
            memRead    <= memReadNext;
            memAddr    <= memAddrNext;
            regAddr1   <= regAddr1Next;
            regAddr2   <= regAddr2Next;
`ifdef DUMP_CHECKSUM_EN
            checksum   <= sumNext;
`endif
        end
    end

endmodule

// File: tb/tb_state_dump_ctrl.sv
// Bench for state_dump_ctrl: two instances (MEM_BYTES 64 and 4) share start,
// outReady and a behavioural register file / byte memory. Accepted beats are
// collected and compared with a beat list built directly from the dump rules.
// Honours DUMP_CHECKSUM_EN when defined.
module tb_state_dump_ctrl;

    localparam int unsigned MEM_A = 64;
    localparam int unsigned MEM_B = 4;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  index;
        logic [31:0] hi;
        logic [31:0] lo;
    } beat_t;
    typedef beat_t beatq_t[$];

    logic clk = 1'b0;
    logic reset, start, outReady;
    logic [23:0] garbage = '0;

    logic        dumpActive [2];
    logic [4:0]  regAddr1   [2];
    logic [4:0]  regAddr2   [2];
    logic [31:0] regData1   [2];
    logic [31:0] regData2   [2];
    logic [31:0] memAddr    [2];
    logic        memRead    [2];
    logic [31:0] memDataIn  [2];
    logic        outValid   [2];
    logic [1:0]  outKind    [2];
    logic [7:0]  outIndex   [2];
    logic [31:0] outDataHi  [2];
    logic [31:0] outDataLo  [2];
    logic        done       [2];

    logic [31:0] regs [32];
    logic [7:0]  mem  [64];

    beatq_t got [2];
    int doneCnt [2];
    int checks = 0;
    int errors = 0;
    bit readyRandom = 1'b0;
    bit startNoise  = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gDut
        state_dump_ctrl #(.MEM_BYTES(g == 0 ? MEM_A : MEM_B)) dut (
            .clk(clk), .reset(reset), .start(start),
            .dumpActive(dumpActive[g]),
            .regAddr1(regAddr1[g]), .regAddr2(regAddr2[g]),
            .regData1(regData1[g]), .regData2(regData2[g]),
            .memAddr(memAddr[g]), .memRead(memRead[g]), .memDataIn(memDataIn[g]),
            .outValid(outValid[g]), .outReady(outReady),
            .outKind(outKind[g]), .outIndex(outIndex[g]),
            .outDataHi(outDataHi[g]), .outDataLo(outDataLo[g]),
            .done(done[g])
        );
        assign regData1[g]  = regs[regAddr1[g]];
        assign regData2[g]  = regs[regAddr2[g]];
        assign memDataIn[g] = {garbage, mem[memAddr[g][5:0]]};
    end

    task automatic expectEq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beatq_t buildExpected(input int unsigned memBytes);
        beatq_t q;
        beat_t b;
        logic [31:0] sum;
        q = {};
        for (int k = 0; k < 16; k++) begin
            b.kind = 2'b00; b.index = 8'(k); b.hi = regs[2*k]; b.lo = regs[2*k+1];
            q.push_back(b);
        end
        for (int w = 0; w < int'(memBytes / 4); w++) begin
            b.kind = 2'b01; b.index = 8'(w); b.hi = '0;
            b.lo = {mem[4*w+3], mem[4*w+2], mem[4*w+1], mem[4*w]};
            q.push_back(b);
        end
        sum = '0;
        foreach (q[i]) sum ^= q[i].hi ^ q[i].lo;
`ifdef DUMP_CHECKSUM_EN
        b.kind = 2'b10; b.index = '0; b.hi = '0; b.lo = sum;
        q.push_back(b);
`endif
        return q;
    endfunction

    function automatic logic [159:0] allOuts(input int g);
        return 160'({dumpActive[g], outValid[g], outKind[g], outIndex[g], outDataHi[g],
                     outDataLo[g], done[g], memRead[g], memAddr[g], regAddr1[g], regAddr2[g]});
    endfunction

    // Collects accepted beats and done pulses; runs before the main thread samples.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!reset && outValid[g] && outReady)
                got[g].push_back(beat_t'({outKind[g], outIndex[g], outDataHi[g], outDataLo[g]}));
            if (done[g] === 1'b1) begin
                doneCnt[g]++;
                expectEq($sformatf("doneIdle%0d", g),
                         160'({dumpActive[g], outValid[g], memRead[g], memAddr[g], regAddr1[g], regAddr2[g]}),
                         160'(0));
            end
        end
    end

    // Background stimulus: memory-bus garbage, random ready, ignored start pulses.
    always @(posedge clk) begin
        #1;
        garbage = 24'($urandom);
        if (readyRandom) outReady = ($urandom_range(0, 9) < 7);
        if (startNoise)
            start = dumpActive[0] && dumpActive[1] && outValid[1] && (outKind[1] == 2'b00)
                    && (outIndex[1] < 8'd10) && ($urandom_range(0, 7) == 0);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    task automatic clearScoreboard();
        for (int g = 0; g < 2; g++) begin
            got[g] = {};
            doneCnt[g] = 0;
        end
    endtask

    task automatic pulseStart();
        drive(); start = 1'b1;
        drive(); start = 1'b0;
    endtask

    task automatic waitBothDone(input int budget);
        int n = 0;
        while (!(doneCnt[0] > 0 && doneCnt[1] > 0) && n < budget) begin
            tick();
            n++;
        end
        expectEq("doneTimeout", 160'(n >= budget), 160'(0));
        repeat (5) tick();
        for (int g = 0; g < 2; g++) begin
            expectEq($sformatf("doneCount%0d", g), 160'(doneCnt[g]), 160'(1));
            expectEq($sformatf("idleAfter%0d", g), 160'(dumpActive[g]), 160'(0));
        end
    endtask

    task automatic compareDumps();
        beatq_t exp;
        for (int g = 0; g < 2; g++) begin
            exp = buildExpected(g == 0 ? MEM_A : MEM_B);
            expectEq($sformatf("beatCount%0d", g), 160'(got[g].size()), 160'(exp.size()));
            for (int i = 0; i < exp.size() && i < got[g].size(); i++)
                expectEq($sformatf("beat%0d_%0d", g, i), 160'(got[g][i]), 160'(exp[i]));
        end
    endtask

    task automatic fillRandom();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    endtask

    task automatic runDump(input bit randReady, input bit noise);
        clearScoreboard();
        readyRandom = randReady;
        if (!randReady) outReady = 1'b1;
        pulseStart();
        startNoise = noise;
        waitBothDone(3000);
        startNoise = 1'b0;
        start = 1'b0;
        compareDumps();
    endtask

    initial begin
        beatq_t expA;
        int n;
        reset = 1'b1; start = 1'b0; outReady = 1'b0;
        fillRandom();
        repeat (3) @(posedge clk);
        tick();
        for (int g = 0; g < 2; g++) expectEq($sformatf("resetOuts%0d", g), allOuts(g), 160'(0));
        drive(); reset = 1'b0;

        // Directed: start latency, known register pair and memory word.
        fillRandom();
        regs[2] = 32'd5; regs[3] = 32'd7;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        clearScoreboard();
        outReady = 1'b1;
        drive(); start = 1'b1;
        drive(); start = 1'b0;
        tick();
        expectEq("loadCycle", 160'({dumpActive[0], outValid[0], regAddr1[0], regAddr2[0]}),
                 160'({1'b1, 1'b0, 5'd0, 5'd1}));
        tick();
        expectEq("firstBeat", 160'({outValid[0], outKind[0], outIndex[0], outDataHi[0], outDataLo[0]}),
                 160'({1'b1, 2'b00, 8'd0, regs[0], regs[1]}));
        pulseStart();
        waitBothDone(3000);
        compareDumps();
        if (got[0].size() > 16) begin
            expectEq("pairOne", 160'({got[0][1].hi, got[0][1].lo}), 160'({32'd5, 32'd7}));
            expectEq("memWord0", 160'({got[0][16].kind, got[0][16].index, got[0][16].lo}),
                     160'({2'b01, 8'd0, 32'h44332211}));
        end
        if (got[1].size() > 16)
            expectEq("memWord0Small", 160'(got[1][16].lo), 160'(32'h44332211));

        // Directed: ten-cycle stall on register beat 3.
        fillRandom();
        expA = buildExpected(MEM_A);
        clearScoreboard();
        readyRandom = 1'b0;
        outReady = 1'b0;
        pulseStart();
        for (int b = 0; b < 4; b++) begin
            n = 0;
            while (outValid[0] !== 1'b1 && n < 20) begin tick(); n++; end
            expectEq("stallWait", 160'(n >= 20), 160'(0));
            if (b == 3) begin
                for (int i = 0; i < 10; i++) begin
                    expectEq("stallPayload", 160'({outValid[0], outKind[0], outIndex[0], outDataHi[0], outDataLo[0]}),
                             160'({1'b1, expA[3]}));
                    tick();
                end
            end
            drive(); outReady = 1'b1;
            drive(); outReady = 1'b0;
            tick();
            if (b == 3)
                expectEq("acceptAfterStall", 160'({outValid[0], regAddr1[0], regAddr2[0]}),
                         160'({1'b0, 5'd8, 5'd9}));
        end
        readyRandom = 1'b1;
        waitBothDone(3000);
        compareDumps();

        // Directed: reset during the second memory gather cycle.
        fillRandom();
        clearScoreboard();
        readyRandom = 1'b0;
        outReady = 1'b1;
        pulseStart();
        n = 0;
        while (!(memRead[0] === 1'b1 && memAddr[0] == 32'd1) && n < 200) begin tick(); n++; end
        expectEq("gatherWait", 160'(n >= 200), 160'(0));
        reset = 1'b1;
        tick();
        for (int g = 0; g < 2; g++) expectEq($sformatf("midReset%0d", g), allOuts(g), 160'(0));
        drive(); reset = 1'b0;
        runDump(1'b0, 1'b0);

        // Directed: zero registers, memory all AA.
        for (int i = 0; i < 32; i++) regs[i] = '0;
        for (int i = 0; i < 64; i++) mem[i] = 8'hAA;
        runDump(1'b1, 1'b0);
`ifdef DUMP_CHECKSUM_EN
        if (got[0].size() > 0)
            expectEq("sumZero", 160'({got[0][$].kind, got[0][$].lo}), 160'({2'b10, 32'h0}));
        if (got[1].size() > 0)
            expectEq("sumAA", 160'({got[1][$].kind, got[1][$].lo}), 160'({2'b10, 32'hAAAAAAAA}));
`endif

        // Random dumps with backpressure and ignored start pulses.
        for (int r = 0; r < 4; r++) begin
            fillRandom();
            runDump(1'b1, 1'b1);
        end

        // start held through completion restarts the cycle after done.
        fillRandom();
        readyRandom = 1'b1;
        drive(); start = 1'b1;
        n = 0;
        while (done[0] !== 1'b1 && n < 3000) begin tick(); n++; end
        expectEq("heldDoneWait", 160'(n >= 3000), 160'(0));
        tick();
        expectEq("restartAfterDone", 160'({dumpActive[0], regAddr1[0], regAddr2[0]}),
                 160'({1'b1, 5'd0, 5'd1}));
        drive(); start = 1'b0; reset = 1'b1;
        readyRandom = 1'b0;
        drive(); reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/state_dump_ctrl.md
STATE_DUMP_CTRL -- requirements
Module: state_dump_ctrl

Interface
REQ-001 Parameter MEM_BYTES, default 64: number of data-memory bytes dumped; SHALL be a multiple of 4 and at least 4.
REQ-002 clk  in  1  processor clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request to begin a dump; sampled only in IDLE.
REQ-005 dumpActive  out  1  high while a dump is in progress; steers the core's register-file read ports and data-memory port to this block.
REQ-006 regAddr1 / regAddr2  out  5 each  register-file read addresses.
REQ-007 regData1 / regData2  in  32 each  register-file read data, valid combinationally in the same cycle.
REQ-008 memAddr  out  32  data-memory byte address.
REQ-009 memRead  out  1  data-memory read enable.
REQ-010 memDataIn  in  32  data-memory read data; only bits [7:0] are used, valid in the same cycle.
REQ-011 outValid  out  1  an output beat is presented.
REQ-012 outReady  in  1  sink accepts the beat.
REQ-013 outKind  out  2  beat type: 00 register pair, 01 memory word, 10 checksum.
REQ-014 outIndex  out  8  beat index within its kind, starting at 0.
REQ-015 outDataHi / outDataLo  out  32 each  beat payload.
REQ-016 done  out  1  one-cycle pulse when the dump completes.

Function
REQ-017 The block SHALL implement the states IDLE, REG_LOAD, REG_EMIT, MEM_GATHER, MEM_EMIT and, when configured, SUM_EMIT.
REQ-018 In IDLE, start=1 at a rising edge SHALL move the block to REG_LOAD with the pair counter at 0; dumpActive SHALL be high in every state except IDLE.
REQ-019 In REG_LOAD the block SHALL drive regAddr1=2k and regAddr2=2k+1, where k is the pair counter, and on the next edge capture regData1 into outDataHi and regData2 into outDataLo, then enter REG_EMIT.
REQ-020 In REG_EMIT the block SHALL hold outValid=1, outKind=00 and outIndex=k.
REQ-021 In REG_EMIT, on an edge with outReady=1: if k<15, increment k and return to REG_LOAD; if k=15, enter MEM_GATHER with the byte address at 0.
REQ-022 In MEM_GATHER, memRead SHALL be 1 and memAddr SHALL be the current byte address.
REQ-023 In MEM_GATHER, each edge SHALL store memDataIn[7:0] into byte lane (address mod 4) of outDataLo, little-endian, and increment the address.
REQ-024 After four MEM_GATHER cycles the block SHALL enter MEM_EMIT with outDataHi=0, outKind=01 and outIndex equal to the word's base address divided by 4.
REQ-025 In MEM_EMIT, on acceptance, the block SHALL return to MEM_GATHER if the address is below MEM_BYTES; otherwise it SHALL enter SUM_EMIT (when configured) or finish.
REQ-026 A beat SHALL transfer only on an edge where outValid=1 and outReady=1.
REQ-027 outKind, outIndex, outDataHi and outDataLo SHALL stay stable while outValid=1 and outReady=0, for any number of cycles.
REQ-028 outReady is don't-care while outValid=0.
REQ-029 Finishing SHALL pulse done=1 for the single cycle after the final acceptance, with the state returning to IDLE and dumpActive low in that same cycle.
REQ-030 start while not in IDLE SHALL be ignored; start held high through completion SHALL begin a new dump the cycle after done.
REQ-031 Outside the states that drive them, memRead, memAddr, regAddr1 and regAddr2 SHALL be 0.
REQ-032 Total beats SHALL be 16 + MEM_BYTES/4 (+1 with checksum); with MEM_BYTES=4 exactly one memory beat SHALL be emitted.

Reset
REQ-033 reset=1 at an edge SHALL force IDLE from any state, including mid-beat or mid-gather, and discard partial data.
REQ-034 After reset, every output SHALL be 0: dumpActive, outValid, outKind, outIndex, outDataHi, outDataLo, done, memRead, memAddr, regAddr1 and regAddr2.
REQ-035 Reset SHALL take priority over start and outReady.

Configuration
REQ-036 Macro DUMP_CHECKSUM_EN, when defined, SHALL add SUM_EMIT and a running 32-bit checksum: the XOR of outDataHi and outDataLo over every accepted beat.
REQ-037 With DUMP_CHECKSUM_EN defined, after the last memory beat the block SHALL emit one beat with outKind=10, outIndex=0, outDataHi=0 and outDataLo equal to the checksum, then finish.
REQ-038 Without DUMP_CHECKSUM_EN, outKind=10 SHALL never occur and no checksum logic SHALL exist.

Verification
REQ-039 Registers r2=5 and r3=7, outReady tied 1, pulse start: first beat has kind 00, index 0, outValid high 2 cycles after start; the beat with index 1 carries Hi=5, Lo=7.
REQ-040 Memory bytes 0..3 = 11,22,33,44 hex: the first memory beat has index 0 and outDataLo=44332211 hex; MEM_BYTES=64 gives 16 memory beats and 32 beats in total.
REQ-041 outReady held 0 for 10 cycles during REG_EMIT with index 3: outValid stays 1 and the payload is unchanged; the beat is accepted on the first edge with outReady=1.
REQ-042 reset asserted during the second MEM_GATHER cycle: the next cycle shows every output 0 and the state IDLE; a new start restarts at register index 0.
REQ-043 With DUMP_CHECKSUM_EN, all registers 0 and memory all AA hex (MEM_BYTES=64): the checksum beat has outDataLo=0; with MEM_BYTES=4 the checksum is AAAAAAAA hex, followed by a done pulse.
REQ-044 start pulsed during REG_EMIT: no effect; exactly one done pulse per dump.
